// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths plus memory-unit state and op encodings.
package cpu_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } mem_op_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, registered read that holds until the next read.
module mem_array #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 16,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage is deliberately left unreset; only the read register clears.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_unit.sv
// Multi-cycle memory front end: request FSM, wait-state counter, address/data latches and range check.
module mem_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic [DATA_W-1:0] RData,
    output logic              MemReady,
    output logic              Busy,
    output logic              Error
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mem_state_t        r_state, w_next;
    mem_op_t           r_op;
    logic [3:0]        r_cnt;
    logic [AW-1:0]     r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_err;
    logic              w_accept, w_reject, w_in_range, w_access;

    assign w_in_range = ({1'b0, Addr} < (ADDR_W+1)'(DEPTH));
    assign w_access   = (r_state == WAIT) && (r_cnt == 4'd0);

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        case (r_state)
            IDLE: begin
                if (MemRead && MemWrite) begin
                    w_reject = 1'b1;
                    w_next   = DONE;
                end else if (MemRead || MemWrite) begin
                    if (w_in_range) begin
                        w_accept = 1'b1;
                        w_next   = WAIT;
                    end else begin
                        w_reject = 1'b1;
                        w_next   = DONE;
                    end
                end
            end
            WAIT:    if (r_cnt == 4'd0) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= OP_RD;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= Addr[AW-1:0];
                r_wdata <= WData;
                r_op    <= MemWrite ? OP_WR : OP_RD;
                r_cnt   <= 4'(WAIT_CYCLES);
                r_err   <= 1'b0;
            end
            if (w_reject) r_err <= 1'b1;
            if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
    end

    // The access edge is the last WAIT edge; a reset before it suppresses the write.
    mem_array #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_array (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_we    (w_access && r_op == OP_WR),
        .i_re    (w_access && r_op == OP_RD),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (RData)
    );

    assign MemReady = (r_state == DONE);
    assign Error    = MemReady && r_err;
    assign Busy     = (r_state != IDLE);

endmodule

// File: tb/tb_mem_unit.sv
// Directed plus randomized checks of mem_unit against a transaction-level memory model.
module tb_mem_unit;

    localparam int W     = 2;
    localparam int DEPTH = 1024;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MemRead, MemWrite;
    logic [15:0] Addr, WData, RData;
    logic        MemReady, Busy, Error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mdl [logic [15:0]];
    logic [15:0] rd_model;
    logic [15:0] pool [8];

    always #5 Clk = ~Clk;

    mem_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Addr     (Addr),
        .WData    (WData),
        .RData    (RData),
        .MemReady (MemReady),
        .Busy     (Busy),
        .Error    (Error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One complete transaction; called just after a falling edge.
    task automatic txn(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d, input bit hold);
        int          n;
        bit          err;
        logic [15:0] exp_rd;
        err    = (rd && wr) || (int'(a) >= DEPTH);
        exp_rd = rd_model;
        if (!err && rd) exp_rd = mdl[a];
        MemRead  = rd;
        MemWrite = wr;
        Addr     = a;
        WData    = d;
        n = 0;
        do begin
            @(posedge Clk);
            n++;
            @(negedge Clk);
            if (n == 1) begin
                chk("busy_after_accept", 32'(Busy), 32'd1);
                if (!hold) begin
                    MemRead  = 1'b0;
                    MemWrite = 1'b0;
                    Addr     = 16'($urandom);
                    WData    = 16'($urandom);
                end
            end
        end while (!MemReady && n < 40);
        chk("latency", n, err ? 32'd1 : 32'(W + 2));
        chk("error", 32'(Error), 32'(err));
        chk("rdata", 32'(RData), 32'(exp_rd));
        if (!err && wr) mdl[a] = d;
        if (!err && rd) rd_model = exp_rd;
        @(posedge Clk);
        @(negedge Clk);
        chk("ready_one_cycle", 32'(MemReady), 32'd0);
        chk("idle_not_busy", 32'(Busy), 32'd0);
        chk("error_low", 32'(Error), 32'd0);
    endtask

    initial begin
        Reset    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Addr     = '0;
        WData    = '0;
        rd_model = '0;
        #1;
        chk("rst_rdata", 32'(RData), 32'd0);
        chk("rst_ready", 32'(MemReady), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_error", 32'(Error), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;

        // write then read back
        txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
        txn(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        txn(1'b0, 1'b1, 16'h0003, 16'h1234, 1'b0);
        txn(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);

        // both strobes: rejected, array[5] and RData untouched
        txn(1'b0, 1'b1, 16'h0005, 16'h0555, 1'b0);
        txn(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        txn(1'b1, 1'b1, 16'h0005, 16'hFFFF, 1'b0);
        txn(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0);

        // out of range and last legal word
        txn(1'b1, 1'b0, 16'h0400, 16'h0000, 1'b0);
        txn(1'b0, 1'b1, 16'h0400, 16'h7777, 1'b0);
        txn(1'b0, 1'b1, 16'h03FF, 16'hC3C3, 1'b0);
        txn(1'b1, 1'b0, 16'h03FF, 16'h0000, 1'b0);
        txn(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0);

        // reset during WAIT aborts the write
        txn(1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0);
        MemWrite = 1'b1;
        Addr     = 16'h0020;
        WData    = 16'hAAAA;
        @(posedge Clk);
        @(negedge Clk);
        MemWrite = 1'b0;
        Reset    = 1'b0;
        #1;
        chk("abort_rdata", 32'(RData), 32'd0);
        chk("abort_ready", 32'(MemReady), 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_error", 32'(Error), 32'd0);
        rd_model = '0;
        @(negedge Clk);
        Reset = 1'b1;
        txn(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);

        // inputs scrambled during WAIT are ignored
        txn(1'b0, 1'b1, 16'h0030, 16'h5555, 1'b0);
        txn(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);

        // request held through DONE starts a second transaction
        txn(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1);
        txn(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);

        // randomized traffic over a preloaded address pool
        for (int i = 0; i < 8; i++) begin
            pool[i] = 16'((i * 131 + 7) % DEPTH);
            txn(1'b0, 1'b1, pool[i], 16'($urandom), 1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            int          op;
            logic [15:0] a;
            op = int'($urandom_range(0, 9));
            a  = pool[$urandom_range(0, 7)];
            if (op == 9) a = 16'($urandom_range(DEPTH, 16'hFFFF));
            case (op)
                0, 1, 2, 3: txn(1'b0, 1'b1, a, 16'($urandom), 1'b0);
                8:          txn(1'b1, 1'b1, a, 16'($urandom), 1'b0);
                9:          txn($urandom_range(0, 1) == 0, 1'b1, a, 16'($urandom), 1'b0);
                default:    txn(1'b1, 1'b0, a, 16'h0000, 1'b0);
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge Clk);
                @(negedge Clk);
                chk("idle_gap_busy", 32'(Busy), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
